// File: rtl/seq_mult_shift_add_pkg.sv
// Shared FSM encoding, default operand width and counter sizing for the shift-add multiplier.
package seq_mult_shift_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Step counter must hold WIDTH without wrapping.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_shift_add_rca.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells, cin tied low.
// Purely combinational; no flow control.
module rca_adder
  import seq_mult_shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-add multiplier: WIDTH RUN cycles plus one DONE cycle per result.
// start is only honoured in IDLE or DONE; requests while busy are dropped.
module seq_mult_shift_add
  import seq_mult_shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int            CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 load, step, finish;
  logic [WIDTH-1:0]     addend, sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   p_shift;

  // Upper half of P is the accumulator; the low half shifts out consumed multiplier bits.
  assign addend  = p_q[0] ? mcand_q : '0;
  assign p_shift = {cout, sum, p_q[WIDTH-1:1]};

  rca_adder #(.WIDTH(WIDTH)) u_add (
    .x    (p_q[2*WIDTH-1:WIDTH]),
    .y    (addend),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (load) begin
      mcand_q <= a;
      p_q     <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if (step) begin
      p_q   <= p_shift;
      cnt_q <= cnt_q + CW'(1);
      // Result is published only on the edge that enters DONE.
      if (finish) begin
        product_q <= p_shift;
      end
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Randomized self-checking bench for seq_mult_shift_add; products predicted with plain arithmetic.
module tb_seq_mult_shift_add;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: quiet operands; 1: random operand/start noise while busy; 2: one stray start (3,3) mid-run
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
    logic [31:0] exp_p;
    int lat, bcnt, dones;
    exp_p = x * y;
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= W + 4; i++) begin
      if (busy) bcnt++;
      if (mode == 1) begin
        a = W'($urandom); b = W'($urandom); start = 1'($urandom_range(0, 1));
      end else if (mode == 2 && i == 3) begin
        a = 3; b = 3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, W);
    chk("busy_cycles", bcnt, W);
    chk("product", product, exp_p);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("single_done", dones, 0);
    chk("idle_busy", busy, 0);
    chk("hold_product", product, exp_p);
  endtask

  initial begin
    int lat;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;

    do_mult(0, 0, 0);
    do_mult(13, 11, 0);
    do_mult(255, 255, 0);
    do_mult(7, 6, 2);
    do_mult(1, 255, 0);
    do_mult(255, 1, 0);

    // Abort mid-run with an asynchronous reset.
    @(posedge clk); #1;
    a = 200; b = 100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    #4 rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done || busy) lat++;
    end
    chk("abort_no_done", lat, 0);
    do_mult(200, 100, 0);

    // Back-to-back: start held in DONE launches the next operation immediately.
    @(posedge clk); #1;
    a = 5; b = 5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk("b2b_lat1", lat, W);
    chk("b2b_prod1", product, 25);
    a = 9; b = 9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rerun", busy, 1);
    chk("b2b_hold", product, 25);
    lat = 1;
    for (int i = 2; i <= W + 5; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk("b2b_lat2", lat, W + 1);
    chk("b2b_prod2", product, 81);

    for (int n = 0; n < 30; n++) begin
      do_mult(W'($urandom), W'($urandom), (n % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
